// File: rtl/power_result_unpack.sv
// power_result_unpack: buffers 64-bit results from the power datapath in a
// small FIFO and re-emits each one as two 32-bit words on a valid/ready port.
// The input side has no back-pressure; a result that arrives while the FIFO is
// full and nothing is popping is dropped and the sticky o_overflow flag is set.
// All outputs are flops, so nothing combinational reaches them from the inputs.
// Optional build macro: RESULT_UNPACK_MSW_FIRST_EN emits the upper word first.
//
// state    | meaning
// ST_EMPTY | no stored result, o_valid low
// ST_LO    | presenting first half of head result
// ST_HI    | presenting second half of head result (o_last high)

module power_result_unpack #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_valid,
    input  logic [IN_WIDTH-1:0]           i_data,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic                          o_last,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IN_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [IN_WIDTH-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;

    logic accept;
    logic pop;
    logic push;
    logic full;

    // Choose which half of a result is shown in the given sub-word state.
    function automatic logic [OUT_WIDTH-1:0] pick_word(input logic [IN_WIDTH-1:0] word,
                                                        input logic second);
`ifdef RESULT_UNPACK_MSW_FIRST_EN
        return second ? word[OUT_WIDTH-1:0] : word[IN_WIDTH-1:OUT_WIDTH];
`else
        return second ? word[IN_WIDTH-1:OUT_WIDTH] : word[OUT_WIDTH-1:0];
`endif
    endfunction

    // Next-state for FIFO, sub-word FSM and the registered output copies.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        state_d    = state_q;

        full   = (count_q == CNT_W'(FIFO_DEPTH));
        accept = valid_q & i_ready;
        pop    = accept & (state_q == ST_HI);
        // A full FIFO still accepts when the head slot is freed on the same edge.
        push   = i_valid & (~full | pop);

        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            count_d         = count_d + CNT_W'(1);
        end
        if (i_valid && !push) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end

        case (state_q)
            ST_EMPTY: if (push) state_d = ST_LO;
            ST_LO:    if (accept) state_d = ST_HI;
            ST_HI:    if (accept) state_d = (count_d != '0) ? ST_LO : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        valid_d = (state_d != ST_EMPTY);
        last_d  = (state_d == ST_HI);
        data_d  = valid_d ? pick_word(mem_d[rd_ptr_d], last_d) : '0;
    end

    // State and output registers; reset drops every stored result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_data     = data_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_power_result_unpack.sv
// Directed bench for power_result_unpack (default build: low word first).
// Inputs change 1 ns after each rising edge; outputs are checked there too.

module tb_power_result_unpack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_ready = 1'b0;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_last;
    logic [2:0]  o_count;
    logic        o_overflow;

    int checks = 0;
    int failures = 0;

    power_result_unpack dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_word(input string tag, input logic [31:0] data, input logic last);
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_data"}, 64'(o_data), 64'(data));
        check({tag, "_last"}, 64'(o_last), 64'(last));
    endtask

    logic [63:0] stream_vals [5] = '{64'd4, 64'd9, 64'd16, 64'd25, 64'd36};
    logic [31:0] drain_vals  [4] = '{32'h12, 32'h13, 32'h14, 32'hAA};

    initial begin
        // reset state
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        do_reset();

        // single result
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'h0000_0001_0000_0019;
        tick();
        i_valid = 1'b0;
        check_word("single_lo", 32'h19, 1'b0);
        check("single_cnt", 64'(o_count), 64'd1);
        tick();
        check_word("single_hi", 32'h1, 1'b1);
        tick();
        check("single_done_valid", 64'(o_valid), 64'd0);
        check("single_done_cnt", 64'(o_count), 64'd0);

        // stream of five, one every two cycles
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = stream_vals[k];
            tick();
            i_valid = 1'b0;
            check_word($sformatf("stream_lo%0d", k), stream_vals[k][31:0], 1'b0);
            tick();
            check_word($sformatf("stream_hi%0d", k), 32'h0, 1'b1);
        end
        tick();
        check("stream_end_valid", 64'(o_valid), 64'd0);
        check("stream_ovf", 64'(o_overflow), 64'd0);

        // overflow: five pushes into four slots with the consumer stalled
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            i_valid = 1'b1;
            i_data  = 64'(k);
            tick();
            if (k == 4) check("ovf_cnt4_flag", 64'(o_overflow), 64'd0);
        end
        i_valid = 1'b0;
        check("ovf_count", 64'(o_count), 64'd4);
        check("ovf_flag", 64'(o_overflow), 64'd1);
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_word($sformatf("ovf_lo%0d", k), 32'(k), 1'b0);
            tick();
            check_word($sformatf("ovf_hi%0d", k), 32'h0, 1'b1);
            tick();
        end
        check("ovf_drain_valid", 64'(o_valid), 64'd0);
        check("ovf_sticky", 64'(o_overflow), 64'd1);
        do_reset();
        check("ovf_cleared", 64'(o_overflow), 64'd0);

        // full with simultaneous pop
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_data  = 64'h11 + 64'(k);
            tick();
        end
        i_valid = 1'b0;
        check("fullpop_cnt_pre", 64'(o_count), 64'd4);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_word("fullpop_head_hi", 32'h0, 1'b1);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'hAA;
        tick();
        i_valid = 1'b0;
        check("fullpop_cnt", 64'(o_count), 64'd4);
        check("fullpop_ovf", 64'(o_overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check_word($sformatf("fullpop_lo%0d", k), drain_vals[k], 1'b0);
            tick();
            check_word($sformatf("fullpop_hi%0d", k), 32'h0, 1'b1);
            tick();
        end
        check("fullpop_end_valid", 64'(o_valid), 64'd0);

        // stall stability in LO
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h0000_00BB_0000_00CC;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_word($sformatf("stall%0d", k), 32'hCC, 1'b0);
            tick();
        end
        i_ready = 1'b1;
        tick();
        check_word("stall_release_hi", 32'hBB, 1'b1);
        tick();
        check("stall_end_valid", 64'(o_valid), 64'd0);

        // asynchronous reset mid-transfer
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = 64'h100 + 64'(k);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("midrst_pre_last", 64'(o_last), 64'd1);
        check("midrst_pre_cnt", 64'(o_count), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_count", 64'(o_count), 64'd0);
        check("midrst_ovf", 64'(o_overflow), 64'd0);
        check("midrst_last", 64'(o_last), 64'd0);
        reset_n = 1'b1;
        tick();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'h0000_0077_0000_0066;
        tick();
        i_valid = 1'b0;
        check_word("midrst_next_lo", 32'h66, 1'b0);
        check("midrst_next_cnt", 64'(o_count), 64'd1);
        tick();
        check_word("midrst_next_hi", 32'h77, 1'b1);
        tick();
        check("midrst_next_end", 64'(o_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
